pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 23 ++
 rtl/pipeline_ctrl.sv | 51 +++++
 tb/tb_pipeline_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and stall/flush/HI-LO controls between pipeline and hazard unit
interface pipeline_ctrl_if;
    logic [4:0]  RS_D, RT_D, RT_E, WriteReg_E, WriteReg_M;
    logic        MemtoReg_E, RegWrite_E, MemtoReg_M, Branch_D;
    logic        MD_Start_E, MD_Op_E, MD_Use_D, MD_Abort;
    logic        Stall_F, Stall_D, Stall_E, Flush_E, Flush_M;
    logic        MD_Go, MD_Busy, MD_Done;
    logic [15:0] Stall_Cnt;
    modport master (
        output RS_D, RT_D, RT_E, WriteReg_E, WriteReg_M,
        output MemtoReg_E, RegWrite_E, MemtoReg_M, Branch_D,
        output MD_Start_E, MD_Op_E, MD_Use_D, MD_Abort,
        input  Stall_F, Stall_D, Stall_E, Flush_E, Flush_M,
        input  MD_Go, MD_Busy, MD_Done, Stall_Cnt
    );
    modport slave (
        input  RS_D, RT_D, RT_E, WriteReg_E, WriteReg_M,
        input  MemtoReg_E, RegWrite_E, MemtoReg_M, Branch_D,
        input  MD_Start_E, MD_Op_E, MD_Use_D, MD_Abort,
        output Stall_F, Stall_D, Stall_E, Flush_E, Flush_M,
        output MD_Go, MD_Busy, MD_Done, Stall_Cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard detection, stall/flush generation and mult/div sequencing
module pipeline_ctrl (
    input logic             clk,
    input logic             rst_n,
    pipeline_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t      state, state_nx;
    logic [3:0]  md_cnt, cnt_nx;
    logic [15:0] stall_cnt;
    logic        lw_stall, br_stall, md_d_stall, busy, done, stall_e, go, stall_any;
    assign lw_stall = bus.MemtoReg_E && bus.RT_E != 5'd0 &&
                      (bus.RT_E == bus.RS_D || bus.RT_E == bus.RT_D);
    assign br_stall = bus.Branch_D &&
        ((bus.RegWrite_E && bus.WriteReg_E != 5'd0 &&
          (bus.WriteReg_E == bus.RS_D || bus.WriteReg_E == bus.RT_D)) ||
         (bus.MemtoReg_M && bus.WriteReg_M != 5'd0 &&
          (bus.WriteReg_M == bus.RS_D || bus.WriteReg_M == bus.RT_D)));
    assign busy       = state != IDLE;
    assign done       = busy && md_cnt == 4'd0 && !bus.MD_Abort;
    assign md_d_stall = bus.MD_Use_D && busy && !done;
    assign stall_e    = bus.MD_Start_E && busy && !done;
    assign go         = bus.MD_Start_E && !stall_e && !bus.MD_Abort && (state == IDLE || done);
    assign stall_any  = lw_stall || br_stall || md_d_stall || stall_e;
    assign bus.Stall_F   = stall_any;
    assign bus.Stall_D   = stall_any;
    assign bus.Stall_E   = stall_e;
    assign bus.Flush_E   = (lw_stall || br_stall || md_d_stall) && !stall_e;
    assign bus.Flush_M   = stall_e;
    assign bus.MD_Go     = go;
    assign bus.MD_Busy   = busy;
    assign bus.MD_Done   = done;
    assign bus.Stall_Cnt = stall_cnt;
    // abort outranks a new start, which outranks completion
    always_comb begin
        state_nx = bus.MD_Abort ? IDLE : go ? (bus.MD_Op_E ? DIV : MUL) : done ? IDLE : state;
        cnt_nx   = bus.MD_Abort ? 4'd0 : go ? (bus.MD_Op_E ? 4'd9 : 4'd4) :
                   (busy && md_cnt != 4'd0) ? md_cnt - 4'd1 : md_cnt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            md_cnt    <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            md_cnt    <= cnt_nx;
            stall_cnt <= (stall_any && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    pipeline_ctrl_if bus ();
    pipeline_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear();
        bus.RS_D = 0; bus.RT_D = 0; bus.RT_E = 0; bus.WriteReg_E = 0; bus.WriteReg_M = 0;
        bus.MemtoReg_E = 0; bus.RegWrite_E = 0; bus.MemtoReg_M = 0; bus.Branch_D = 0;
        bus.MD_Start_E = 0; bus.MD_Op_E = 0; bus.MD_Use_D = 0; bus.MD_Abort = 0;
    endtask
    initial begin
        clear();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_busy", {15'd0, bus.MD_Busy}, 16'd0);
        chk("rst_done", {15'd0, bus.MD_Done}, 16'd0);
        chk("rst_cnt", bus.Stall_Cnt, 16'd0);
        chk("rst_stall_f", {15'd0, bus.Stall_F}, 16'd0);
        // MD_Go is purely combinational even while held in reset
        bus.MD_Start_E = 1; #1;
        chk("rst_go_comb", {15'd0, bus.MD_Go}, 16'd1);
        tick();
        chk("rst_hold_idle", {15'd0, bus.MD_Busy}, 16'd0);
        // mult accepted on the first cycle after reset
        rst_n = 1'b1; bus.MD_Op_E = 0; #1;
        chk("mul_go", {15'd0, bus.MD_Go}, 16'd1);
        chk("mul_no_stall_e", {15'd0, bus.Stall_E}, 16'd0);
        chk("mul_no_stall_d", {15'd0, bus.Stall_D}, 16'd0);
        tick();
        bus.MD_Start_E = 0; bus.MD_Use_D = 1; #1;
        chk("mul_busy_t1", {15'd0, bus.MD_Busy}, 16'd1);
        chk("mul_done_t1", {15'd0, bus.MD_Done}, 16'd0);
        chk("mul_stall_d_t1", {15'd0, bus.Stall_D}, 16'd1);
        chk("mul_flush_e_t1", {15'd0, bus.Flush_E}, 16'd1);
        chk("mul_go_t1", {15'd0, bus.MD_Go}, 16'd0);
        tick(); tick(); tick();
        chk("mul_stall_d_t4", {15'd0, bus.Stall_D}, 16'd1);
        chk("mul_done_t4", {15'd0, bus.MD_Done}, 16'd0);
        tick();
        chk("mul_done_t5", {15'd0, bus.MD_Done}, 16'd1);
        chk("mul_busy_t5", {15'd0, bus.MD_Busy}, 16'd1);
        chk("mul_stall_d_t5", {15'd0, bus.Stall_D}, 16'd0);
        chk("mul_cnt_t5", bus.Stall_Cnt, 16'd4);
        tick();
        bus.MD_Use_D = 0; #1;
        chk("mul_idle_t6", {15'd0, bus.MD_Busy}, 16'd0);
        chk("mul_done_t6", {15'd0, bus.MD_Done}, 16'd0);
        // load-use hazard
        bus.MemtoReg_E = 1; bus.RT_E = 8; bus.RS_D = 8; #1;
        chk("lw_stall_f", {15'd0, bus.Stall_F}, 16'd1);
        chk("lw_stall_d", {15'd0, bus.Stall_D}, 16'd1);
        chk("lw_flush_e", {15'd0, bus.Flush_E}, 16'd1);
        chk("lw_flush_m", {15'd0, bus.Flush_M}, 16'd0);
        tick();
        clear(); #1;
        chk("lw_cnt", bus.Stall_Cnt, 16'd5);
        chk("lw_released", {15'd0, bus.Stall_D}, 16'd0);
        bus.MemtoReg_E = 1; bus.RT_E = 0; bus.RS_D = 0; #1;
        chk("lw_r0", {15'd0, bus.Stall_D}, 16'd0);
        bus.MemtoReg_E = 1; bus.RT_E = 9; bus.RS_D = 3; bus.RT_D = 9; #1;
        chk("lw_rt_d", {15'd0, bus.Stall_D}, 16'd1);
        clear();
        // branch hazards
        bus.Branch_D = 1; bus.RegWrite_E = 1; bus.WriteReg_E = 0; bus.RS_D = 0; #1;
        chk("br_r0", {15'd0, bus.Stall_D}, 16'd0);
        bus.WriteReg_E = 5; bus.RS_D = 5; #1;
        chk("br_e_stall_d", {15'd0, bus.Stall_D}, 16'd1);
        chk("br_e_flush_e", {15'd0, bus.Flush_E}, 16'd1);
        tick();
        bus.RegWrite_E = 0; bus.MemtoReg_M = 1; bus.WriteReg_M = 7; bus.RT_D = 7; #1;
        chk("br_m_stall_d", {15'd0, bus.Stall_D}, 16'd1);
        tick();
        clear(); #1;
        chk("br_cnt", bus.Stall_Cnt, 16'd7);
        // back-to-back: div then a queued div
        bus.MD_Start_E = 1; bus.MD_Op_E = 1; #1;
        chk("b2b_go_t0", {15'd0, bus.MD_Go}, 16'd1);
        tick();
        bus.MD_Start_E = 0;
        tick(); tick();
        bus.MD_Start_E = 1; bus.MD_Op_E = 1; #1;
        chk("b2b_flush_e_t3", {15'd0, bus.Flush_E}, 16'd0);
        for (int i = 3; i <= 9; i++) begin
            chk($sformatf("b2b_stall_e_t%0d", i), {15'd0, bus.Stall_E}, 16'd1);
            chk($sformatf("b2b_flush_m_t%0d", i), {15'd0, bus.Flush_M}, 16'd1);
            chk($sformatf("b2b_go_t%0d", i), {15'd0, bus.MD_Go}, 16'd0);
            tick();
        end
        chk("b2b_done_t10", {15'd0, bus.MD_Done}, 16'd1);
        chk("b2b_go_t10", {15'd0, bus.MD_Go}, 16'd1);
        chk("b2b_stall_e_t10", {15'd0, bus.Stall_E}, 16'd0);
        chk("b2b_cnt", bus.Stall_Cnt, 16'd14);
        tick();
        bus.MD_Start_E = 0; #1;
        chk("b2b_busy_t11", {15'd0, bus.MD_Busy}, 16'd1);
        chk("b2b_done_t11", {15'd0, bus.MD_Done}, 16'd0);
        repeat (9) tick();
        chk("b2b_done_t20", {15'd0, bus.MD_Done}, 16'd1);
        tick();
        chk("b2b_idle_t21", {15'd0, bus.MD_Busy}, 16'd0);
        // abort mid-div
        bus.MD_Start_E = 1; bus.MD_Op_E = 1; #1;
        chk("ab_go", {15'd0, bus.MD_Go}, 16'd1);
        tick();
        bus.MD_Start_E = 0;
        tick(); tick(); tick();
        bus.MD_Abort = 1; #1;
        chk("ab_busy_t4", {15'd0, bus.MD_Busy}, 16'd1);
        chk("ab_done_t4", {15'd0, bus.MD_Done}, 16'd0);
        tick();
        bus.MD_Abort = 0; #1;
        chk("ab_busy_t5", {15'd0, bus.MD_Busy}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ab_no_done_%0d", i), {15'd0, bus.MD_Done}, 16'd0);
            tick();
        end
        // abort on the done cycle, with a start pending
        bus.MD_Start_E = 1; bus.MD_Op_E = 0; #1;
        chk("abd_go", {15'd0, bus.MD_Go}, 16'd1);
        tick();
        bus.MD_Start_E = 0;
        repeat (4) tick();
        bus.MD_Abort = 1; bus.MD_Start_E = 1; #1;
        chk("abd_done", {15'd0, bus.MD_Done}, 16'd0);
        chk("abd_go_suppr", {15'd0, bus.MD_Go}, 16'd0);
        tick();
        clear(); #1;
        chk("abd_idle", {15'd0, bus.MD_Busy}, 16'd0);
        // reset in the middle of a mult
        bus.MD_Start_E = 1; #1;
        tick();
        bus.MD_Start_E = 0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("rmid_busy", {15'd0, bus.MD_Busy}, 16'd0);
        chk("rmid_cnt", bus.Stall_Cnt, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("rmid_stays_idle", {15'd0, bus.MD_Busy}, 16'd0);
        // saturation of the stall counter
        bus.MemtoReg_E = 1; bus.RT_E = 8; bus.RS_D = 8;
        repeat (65534) tick();
        chk("sat_fffe", bus.Stall_Cnt, 16'hFFFE);
        repeat (6) tick();
        chk("sat_ffff", bus.Stall_Cnt, 16'hFFFF);
        clear();
        tick();
        chk("sat_hold", bus.Stall_Cnt, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
